// File: rtl/uart_tx_sequencer.sv
// Bus master that programs the MiniUART divisor and drains a byte FIFO into DATA, polling LSR before each write.
// Optional ack watchdog is compiled in with `define UART_SEQ_TIMEOUT_EN.
module uart_tx_sequencer #(
  parameter int unsigned AW       = 3,
  parameter logic [31:0] DIVT_RST = 32'h9,
  parameter logic [2:0]  OFF_DATA = 3'd0,
  parameter logic [2:0]  OFF_DIVT = 3'd1,
  parameter logic [2:0]  OFF_LSR  = 3'd2,
  parameter int unsigned TXE_BIT  = 5,
  parameter int unsigned TMO      = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          div_we_i,
  input  logic [31:0]   div_val_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          busy_o,
  output logic          err_o,
  output logic [2:0]    u_off_o,
  output logic [31:0]   u_din_o,
  input  logic [31:0]   u_dout_i,
  output logic          u_stb_o,
  output logic          u_we_o,
  input  logic          u_ack_i
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_POLL  = 3'd2,
    S_CHECK = 3'd3,
    S_SEND  = 3'd4
  } state_t;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

  state_t      state_q, state_d;
  logic        stb_q, stb_d, we_q, we_d, txe_q, txe_d;
  logic        div_pend_q, div_pend_d, ovf_q, ovf_d;
  logic [2:0]  off_q, off_d;
  logic [31:0] din_q, din_d, div_val_q, div_val_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0]  mem_q [2**AW];
  logic        ack_s, pop_s, push_ok_s, tmo_hit_s, unused_s;

  assign count_o   = wr_q - rd_q;
  assign full_o    = (count_o == DEPTH);
  assign empty_o   = (wr_q == rd_q);
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q != S_IDLE);
  assign u_stb_o   = stb_q;
  assign u_we_o    = we_q;
  assign u_off_o   = off_q;
  assign u_din_o   = din_q;
  assign ack_s     = stb_q & u_ack_i;
  assign push_ok_s = push_i & (~full_o | pop_s);
  assign unused_s  = ^{u_dout_i, 32'(TMO)};

  // Next-state, bus-cycle and FIFO pointer logic
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    we_d       = we_q;
    off_d      = off_q;
    din_d      = din_q;
    txe_d      = txe_q;
    div_pend_d = div_pend_q;
    div_val_d  = div_val_q;
    pop_s      = 1'b0;
    case (state_q)
      S_INIT: begin
        if (ack_s) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_IDLE;
        end else if (!stb_q) begin
          stb_d      = 1'b1;
          we_d       = 1'b1;
          off_d      = OFF_DIVT;
          din_d      = div_val_q;
          div_pend_d = 1'b0;
        end else begin
          stb_d = 1'b1;
        end
      end
      S_IDLE: begin
        // The request is consumed when the DIVT write is issued, so a newer div_we survives
        if (div_pend_q) begin
          state_d    = S_INIT;
          stb_d      = 1'b1;
          we_d       = 1'b1;
          off_d      = OFF_DIVT;
          din_d      = div_val_q;
          div_pend_d = 1'b0;
        end else if (!empty_o) begin
          state_d = S_POLL;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          off_d   = OFF_LSR;
          din_d   = 32'h0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POLL: begin
        if (ack_s) begin
          stb_d   = 1'b0;
          txe_d   = u_dout_i[TXE_BIT];
          state_d = S_CHECK;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b0;
          off_d = OFF_LSR;
          din_d = 32'h0;
        end else begin
          stb_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (txe_q) begin
          state_d = S_SEND;
        end else begin
          state_d = S_POLL;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          off_d   = OFF_LSR;
          din_d   = 32'h0;
        end
      end
      S_SEND: begin
        if (ack_s) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          pop_s   = 1'b1;
          state_d = S_IDLE;
        end else if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          off_d = OFF_DATA;
          din_d = {24'h0, mem_q[rd_q[AW-1:0]]};
        end else begin
          stb_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        stb_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
    // Watchdog abort leaves the FIFO head in place and re-arms an interrupted divisor write
    if (tmo_hit_s) begin
      stb_d   = 1'b0;
      we_d    = 1'b0;
      state_d = S_IDLE;
      if (state_q == S_INIT) begin
        div_pend_d = 1'b1;
      end else begin
        div_pend_d = div_pend_d;
      end
    end else begin
      state_d = state_d;
    end
    if (div_we_i) begin
      div_pend_d = 1'b1;
      div_val_d  = div_val_i;
    end else begin
      div_val_d = div_val_q;
    end
    wr_d  = push_ok_s ? (wr_q + PTR_ONE) : wr_q;
    rd_d  = pop_s ? (rd_q + PTR_ONE) : rd_q;
    ovf_d = ovf_q | (push_i & ~push_ok_s);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      off_q      <= 3'd0;
      din_q      <= 32'h0;
      txe_q      <= 1'b0;
      div_pend_q <= 1'b1;
      div_val_q  <= DIVT_RST;
      wr_q       <= {(AW+1){1'b0}};
      rd_q       <= {(AW+1){1'b0}};
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      off_q      <= off_d;
      din_q      <= din_d;
      txe_q      <= txe_d;
      div_pend_q <= div_pend_d;
      div_val_q  <= div_val_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok_s) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

`ifdef UART_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit_s = stb_q & ~u_ack_i & (tmo_q == TW'(TMO - 1));
  assign err_o     = err_q;

  // Ack watchdog counter and sticky error
  always_comb begin
    if (stb_q & ~u_ack_i & ~tmo_hit_s) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = {TW{1'b0}};
    end
    err_d = err_q | tmo_hit_s;
  end

  // Watchdog registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= {TW{1'b0}};
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule
